gray_conv_arbiter: RTL



---
 rtl/gray_conv_arbiter_pkg.sv | 15 +
 rtl/gray_conv_stage.sv | 27 ++
 rtl/gray_conv_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/gray_conv_arbiter_pkg.sv
// Shared mode encodings and elaboration helpers for the Gray conversion arbiter.
package gray_conv_arbiter_pkg;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  // Ceiling log2, used to confirm the id field can hold every requester index.
  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/gray_conv_stage.sv
// Combinational binary<->Gray converter; mode selects the direction.
module gray_conv_stage
  import gray_conv_arbiter_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] data_i,
  input  logic         mode_i,
  output logic [W-1:0] result_o
);

  // Gray encode is a single XOR; Gray decode is a prefix XOR from the MSB down.
  always_comb begin
    logic [W-1:0] bin;
    bin      = '0;
    bin[W-1] = data_i[W-1];
    for (int k = W - 2; k >= 0; k--) begin
      bin[k] = bin[k+1] ^ data_i[k];
    end
    if (mode_i == MODE_G2B) begin
      result_o = bin;
    end else begin
      result_o = data_i ^ (data_i >> 1);
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one registered Gray conversion stage among N_REQ requesters.
module gray_conv_arbiter
  import gray_conv_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_data,
  input  logic [N_REQ-1:0]   req_mode,
  output logic [N_REQ-1:0]   req_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output logic [IDW-1:0]     out_id,
  output logic               out_mode,
  input  logic               out_ready
);

  if (IDW < clog2_f(N_REQ)) begin : g_idw_check
    $error("gray_conv_arbiter: IDW too narrow for N_REQ");
  end

  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [IDW-1:0]   out_id_q, out_id_d;
  logic             out_mode_q, out_mode_d;

  logic             found;
  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   gnt_next;
  logic [W-1:0]     sel_data;
  logic             sel_mode;
  logic [W-1:0]     conv_data;
  logic             slot_free;
  logic             accept;

  // Priority search starting at rr_ptr with wrap; also muxes the winner's data and mode.
  always_comb begin
    found    = 1'b0;
    grant    = '0;
    gnt_idx  = '0;
    gnt_next = '0;
    sel_data = '0;
    sel_mode = MODE_B2G;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = IDW'(idx);
        gnt_next   = (idx == N_REQ - 1) ? '0 : IDW'(idx + 1);
        sel_data   = req_data[idx*W +: W];
        sel_mode   = req_mode[idx];
      end
    end
  end

  assign slot_free = !out_valid_q || out_ready;
  // Grants are suppressed while reset is asserted so nothing looks accepted.
  assign req_ready = (rst_n && slot_free) ? grant : '0;
  assign accept    = |req_ready;

  gray_conv_stage #(.W(W)) u_conv (
    .data_i   (sel_data),
    .mode_i   (sel_mode),
    .result_o (conv_data)
  );

  // Next state: load on accept (replacing any draining result), else drop valid on drain.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_mode_d  = out_mode_q;
    if (accept) begin
      rr_ptr_d    = gnt_next;
      out_valid_d = 1'b1;
      out_data_d  = conv_data;
      out_id_d    = gnt_idx;
      out_mode_d  = sel_mode;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and round-robin pointer; reset discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_mode_q  <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_mode_q  <= out_mode_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_mode  = out_mode_q;

endmodule
